hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline-wide stall/bubble/flush controller for the 5-stage RV32I core. Sits beside the
//  IF/ID-ID/EX boundary, upstream of EX forwarding: resolves what forwarding cannot (load-use,
//  I/D memory wait, EX redirect). Drives per-stage register load enables and NOP-insert flushes.
//  Keeps a small wait FSM and saturating hazard performance counters.
// PARAMETERS
//  CNT_W  32  width of each performance counter (saturating)
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      asynchronous active-low reset
//  ifid_rs1       in   5      rs1 of instruction in ID
//  ifid_rs2       in   5      rs2 of instruction in ID
//  ifid_uses_rs1  in   1      ID instruction reads rs1
//  ifid_uses_rs2  in   1      ID instruction reads rs2
//  idex_opcode    in   7      rv32i_opcode of instruction in EX
//  idex_rd        in   5      rd of instruction in EX
//  ex_redirect    in   1      EX resolved taken branch / jal / jalr
//  imem_read      in   1      IF has fetch outstanding
//  imem_resp      in   1      I-side response this cycle
//  dmem_active    in   1      MEM stage holds load/store
//  dmem_resp      in   1      D-side response this cycle
//  load_pc        out  1      PC register enable
//  load_ifid      out  1      IF/ID enable
//  load_idex      out  1      ID/EX enable
//  load_exmem     out  1      EX/MEM enable
//  load_memwb     out  1      MEM/WB enable
//  flush_ifid     out  1      IF/ID loads NOP (valid only with load_ifid)
//  flush_idex     out  1      ID/EX loads NOP (valid only with load_idex)
//  stall_cnt      out  CNT_W  cycles with any stage frozen
//  bubble_cnt     out  CNT_W  load-use bubbles inserted
//  flush_cnt      out  CNT_W  EX redirects taken
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN; load_*=0; flush_*=1; all counters=0.
//  Terms: dstall = dmem_active & ~dmem_resp; istall = imem_read & ~imem_resp;
//   lu = (idex_opcode==op_load) & idex_rd!=0 & ((uses_rs1&rs1==idex_rd)|(uses_rs2&rs2==idex_rd)).
//  Priority, evaluated combinationally each cycle (highest first):
//   1 dstall: all load_*=0, flush_*=0 (full freeze).
//   2 istall & ex_redirect: full freeze; redirect applied in cycle imem_resp arrives.
//   3 ex_redirect: all load_*=1, flush_ifid=1, flush_idex=1 (2 wrong-path slots killed).
//   4 istall: load_pc=load_ifid=0; load_idex=1 with flush_idex=1; exmem/memwb advance.
//   5 lu: load_pc=load_ifid=0; load_idex=1, flush_idex=1 (exactly one bubble); rest advance.
//   6 else: all load_*=1, flush_*=0.
//  lu is masked when ex_redirect (ID instruction is wrong-path).
//  FSM (registered): RUN -> DWAIT on dstall; RUN -> IWAIT on istall & ~dstall;
//   DWAIT -> RUN on dmem_resp (if istall still true -> IWAIT); IWAIT -> RUN on imem_resp;
//   IWAIT -> DWAIT if dstall rises. State informs counters only; outputs follow priority list.
//  Counters: +1 per cycle when rule 1,2,4 or 5 applies (stall_cnt); +1 per rule-5 cycle
//   (bubble_cnt); +1 per rule-3 cycle (flush_cnt). Saturate at all-ones, never wrap.
//  Simultaneous dmem_resp & imem_resp: both waits end same cycle; state -> RUN.
//  Reset mid-stall: FSM and counters clear immediately; no pending redirect retained.
//  Latency: all controls are same-cycle combinational; no added pipeline delay.
// STRUCTURE
//  rv32i_types: reuse rv32i_opcode (op_load); add enum hz_state_t {HZ_RUN,HZ_IWAIT,HZ_DWAIT}.
//  Sub-module: sat_counter #(CNT_W) (inc, clk, rst_n, count) instantiated 3x.
// TESTING
//  lw x5 in EX, add x6,x5,x1 in ID -> 1 cycle load_pc=load_ifid=0, flush_idex=1, bubble_cnt=1.
//  lw x0 in EX, ID reads x0 -> no bubble, all load_*=1, bubble_cnt=0.
//  dmem_active with dmem_resp after 3 cycles -> 3 cycles all load_*=0, stall_cnt=3, then RUN.
//  ex_redirect=1 with no stalls -> flush_ifid=flush_idex=1, all loads 1, flush_cnt=1.
//  istall + ex_redirect for 2 cycles then imem_resp -> 2 full freezes, redirect on resp cycle.
//  CNT_W=4, 20 stall cycles -> stall_cnt holds 4'hF; assert rst_n=0 mid-stall -> counts 0, RUN.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard stall/bubble/flush controller:
// RV32I opcode encodings, wait-FSM states, hazard rule classification.
package hazard_stall_ctrl_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_IWAIT = 2'd1,
        HZ_DWAIT = 2'd2
    } hz_state_t;

    // Which row of the priority list is in effect this cycle.
    typedef enum logic [2:0] {
        RULE_DFREEZE  = 3'd0,
        RULE_IFREEZE  = 3'd1,
        RULE_REDIRECT = 3'd2,
        RULE_ISTALL   = 3'd3,
        RULE_LOADUSE  = 3'd4,
        RULE_RUN      = 3'd5
    } hz_rule_t;

    // Load in EX writing a register the ID instruction reads; x0 never hazards.
    function automatic logic load_use_hit(
        input logic [6:0] ex_opcode,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs1,
        input logic       id_uses_rs2
    );
        logic is_load;
        is_load = (ex_opcode == 7'(op_load));
        return is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    endfunction

    // Rules that hold at least one stage frozen.
    function automatic logic rule_is_stall(input hz_rule_t r);
        return (r == RULE_DFREEZE) || (r == RULE_IFREEZE) ||
               (r == RULE_ISTALL)  || (r == RULE_LOADUSE);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) reports
// ID/EX operands and memory handshake status; the controller (slave) returns
// per-stage load enables and NOP-insert flushes.
interface hazard_stall_ctrl_if;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_uses_rs1;
    logic       ifid_uses_rs2;
    logic [6:0] idex_opcode;
    logic [4:0] idex_rd;
    logic       ex_redirect;
    logic       imem_read;
    logic       imem_resp;
    logic       dmem_active;
    logic       dmem_resp;

    logic       load_pc;
    logic       load_ifid;
    logic       load_idex;
    logic       load_exmem;
    logic       load_memwb;
    logic       flush_ifid;
    logic       flush_idex;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
        output idex_opcode, idex_rd, ex_redirect,
        output imem_read, imem_resp, dmem_active, dmem_resp,
        input  load_pc, load_ifid, load_idex, load_exmem, load_memwb,
        input  flush_ifid, flush_idex
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
        input  idex_opcode, idex_rd, ex_redirect,
        input  imem_read, imem_resp, dmem_active, dmem_resp,
        output load_pc, load_ifid, load_idex, load_exmem, load_memwb,
        output flush_ifid, flush_idex
    );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter for hazard performance statistics; sticks at
// all-ones instead of wrapping so long runs never under-report.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + ONE;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble/flush controller for the 5-stage RV32I pipeline. Resolves
// hazards forwarding cannot: D-side wait, I-side wait, EX redirect and
// load-use. All stage controls are combinational in the same cycle; the
// wait FSM and counters are the only state.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hazard_stall_ctrl_if.slave     bus,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    hz_rule_t  rule;

    logic dstall;
    logic istall;
    logic lu;

    logic load_pc;
    logic load_ifid;
    logic load_idex;
    logic load_exmem;
    logic load_memwb;
    logic flush_ifid;
    logic flush_idex;

    logic stall_inc;
    logic bubble_inc;
    logic flush_inc;

    assign dstall = bus.dmem_active & ~bus.dmem_resp;
    assign istall = bus.imem_read & ~bus.imem_resp;
    // A redirect means the ID instruction is wrong-path, so its hazard is moot.
    assign lu     = load_use_hit(bus.idex_opcode, bus.idex_rd, bus.ifid_rs1,
                                 bus.ifid_rs2, bus.ifid_uses_rs1,
                                 bus.ifid_uses_rs2) & ~bus.ex_redirect;

    // Select the highest-priority hazard rule for this cycle.
    always_comb begin
        rule = RULE_RUN;
        if (dstall) begin
            rule = RULE_DFREEZE;
        end else if (istall && bus.ex_redirect) begin
            // Redirect waits for the fetch to land so the old response is not
            // mistaken for the target instruction.
            rule = RULE_IFREEZE;
        end else if (bus.ex_redirect) begin
            rule = RULE_REDIRECT;
        end else if (istall) begin
            rule = RULE_ISTALL;
        end else if (lu) begin
            rule = RULE_LOADUSE;
        end
    end

    // Stage enables and flushes from the selected rule; reset forces NOPs.
    always_comb begin
        load_pc    = 1'b1;
        load_ifid  = 1'b1;
        load_idex  = 1'b1;
        load_exmem = 1'b1;
        load_memwb = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rst_n) begin
            load_pc    = 1'b0;
            load_ifid  = 1'b0;
            load_idex  = 1'b0;
            load_exmem = 1'b0;
            load_memwb = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else begin
            unique case (rule)
                RULE_DFREEZE, RULE_IFREEZE: begin
                    load_pc    = 1'b0;
                    load_ifid  = 1'b0;
                    load_idex  = 1'b0;
                    load_exmem = 1'b0;
                    load_memwb = 1'b0;
                end
                RULE_REDIRECT: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                RULE_ISTALL, RULE_LOADUSE: begin
                    // Hold front end, push a bubble into EX, drain the back end.
                    load_pc    = 1'b0;
                    load_ifid  = 1'b0;
                    flush_idex = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Wait-state tracking; informs statistics only, never the stage controls.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HZ_RUN: begin
                if (dstall) begin
                    state_d = HZ_DWAIT;
                end else if (istall) begin
                    state_d = HZ_IWAIT;
                end
            end
            HZ_DWAIT: begin
                if (bus.dmem_resp || !bus.dmem_active) begin
                    state_d = istall ? HZ_IWAIT : HZ_RUN;
                end
            end
            HZ_IWAIT: begin
                if (dstall) begin
                    state_d = HZ_DWAIT;
                end else if (bus.imem_resp || !bus.imem_read) begin
                    state_d = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    // Wait-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_inc  = rule_is_stall(rule);
    assign bubble_inc = (rule == RULE_LOADUSE);
    assign flush_inc  = (rule == RULE_REDIRECT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign bus.load_pc    = load_pc;
    assign bus.load_ifid  = load_ifid;
    assign bus.load_idex  = load_idex;
    assign bus.load_exmem = load_exmem;
    assign bus.load_memwb = load_memwb;
    assign bus.flush_ifid = flush_ifid;
    assign bus.flush_idex = flush_idex;

endmodule
